pipe_fetch: RTL
===============

PIPE_FETCH -- requirements
Module: pipe_fetch

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 clrn  in  1  reset; synchronous, active-low, sampled on the rising clk edge.
REQ-003 INSTALL  in  1  pipeline advance: 1 = IF/ID loads this cycle, 0 = stall.
REQ-004 pcsource  in  2  next-PC select: 00 = pc+4, 01 = bpc, 10 = da, 11 = jpc.
REQ-005 bpc  in  32  branch target.
REQ-006 da  in  32  register (jr) target.
REQ-007 jpc  in  32  jump target.
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  request address; equals the current pc.
REQ-010 imem_ack  in  1  memory completion; meaningful only while imem_req=1.
REQ-011 imem_rdata  in  32  instruction word; valid in the imem_ack cycle.
REQ-012 pc4  out  32  pc+4 of the presented instruction; feeds the IF/ID pc4 input.
REQ-013 ins  out  32  presented instruction, or 32'h0 (NOP) when fvalid=0.
REQ-014 fvalid  out  1  ins holds a real fetched instruction.
REQ-015 misalign  out  1  one-cycle pulse when the selected next-PC has bits [1:0] != 00.

Function
REQ-016 The block SHALL implement a three-state machine: IDLE, REQ, HOLD.
REQ-017 IDLE: imem_req=0, fvalid=0; next state is always REQ.
REQ-018 REQ: imem_req=1, imem_addr=pc; pc SHALL stay stable while imem_ack=0.
REQ-019 REQ with imem_ack=1: capture imem_rdata into the instruction register; next state HOLD.
REQ-020 REQ with imem_ack=0: remain in REQ with no limit on wait cycles.
REQ-021 HOLD: imem_req=0, fvalid=1, ins=captured word, pc4=pc+4.
REQ-022 HOLD with INSTALL=1: pc <= selected next-PC; next state REQ.
REQ-023 HOLD with INSTALL=0: hold pc, ins and state.
REQ-024 While fvalid=0, ins SHALL be 32'h0 and pc4 SHALL be pc+4.
  - The IF/ID register therefore loads a bubble when INSTALL=1.
REQ-025 pcsource, bpc, da and jpc SHALL be sampled only in the HOLD cycle with INSTALL=1; other values are ignored.
REQ-026 Next-PC arithmetic is 32-bit modulo 2^32.
  - Example: pc=32'hFFFF_FFFC with pcsource=00 yields 32'h0000_0000.
REQ-027 The next-PC SHALL be written with bits [1:0] forced to 00.
  - misalign SHALL pulse for exactly that handoff cycle when the unmasked value had nonzero [1:0].
REQ-028 imem_ack received while imem_req=0 (IDLE or HOLD) SHALL be ignored and SHALL not change state.
REQ-029 Throughput is 1 instruction per 2 cycles with zero-wait memory.
  - ack in the first REQ cycle, then HOLD with INSTALL=1.
  - Each memory wait cycle adds 1 cycle.

Reset
REQ-030 clrn=0 at a clock edge SHALL force state=IDLE, pc=32'h0 and instruction register=32'h0.
  - This holds from any state, including mid-request.
REQ-031 During and immediately after reset: imem_req=0, fvalid=0, ins=32'h0, pc4=32'h4, misalign=0.
REQ-032 The first request after clrn returns to 1 SHALL issue from address 32'h0.
  - It issues one cycle later, via IDLE.
  - A stale ack from a pre-reset request arriving during IDLE is discarded per REQ-028.

Verification
REQ-033 Reset, then zero-wait memory returning 32'h2000_0001, INSTALL=1, pcsource=00.
  - Required: imem_addr sequence 0, 4, 8.
  - Required: fvalid high every second cycle with ins=32'h2000_0001, pc4=4 then 8.
REQ-034 Memory inserts 3 wait cycles at address 0.
  - Required: imem_req held, imem_addr=0 for 4 cycles.
  - Required: fvalid=0 and ins=0 throughout, then HOLD.
REQ-035 In HOLD, INSTALL=0 for 5 cycles, then 1 with pcsource=01, bpc=32'h0000_0040.
  - Required: ins and pc4 stable for 5 cycles.
  - Required: next imem_addr=32'h40.
REQ-036 In HOLD, handoff with pcsource=10, da=32'h0000_0106.
  - Required: misalign=1 for one cycle; next imem_addr=32'h104.
REQ-037 clrn=0 in REQ at pc=32'h80, memory acks in the first cycle after clrn=1.
  - Required: ack ignored in IDLE.
  - Required: next request at address 0, fvalid=0 until the new ack.
REQ-038 pc=32'hFFFF_FFFC, handoff with pcsource=00.
  - Required: pc4=32'h0 while presenting; next imem_addr=32'h0.

Source files
------------

// File: rtl/pipe_fetch.sv
// Instruction fetch stage: IDLE -> REQ -> HOLD loop presenting one instruction to IF/ID.
// Latency: 2 cycles per instruction with a zero-wait memory; each memory wait cycle adds 1.
// Backpressure: memory stalls hold REQ (pc stable); INSTALL=0 holds HOLD (pc, ins stable).
module pipe_fetch (
  input  logic        clk,
  input  logic        clrn,
  input  logic        INSTALL,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] da,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc4,
  output logic [31:0] ins,
  output logic        fvalid,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_plus4;
  logic [31:0] npc_raw;

  // Sequential pc+4 and the unmasked next-PC candidate chosen by pcsource.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    npc_raw  = pc_plus4;
    case (pcsource)
      2'b00:   npc_raw = pc_plus4;
      2'b01:   npc_raw = bpc;
      2'b10:   npc_raw = da;
      default: npc_raw = jpc;
    endcase
  end

  // Next-state, pc/instruction register updates and the fetch handshake outputs.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    imem_req = 1'b0;
    fvalid   = 1'b0;
    misalign = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        fvalid = 1'b1;
        if (INSTALL) begin
          // Target is word-aligned on write; a non-aligned request is flagged for one cycle.
          pc_d     = {npc_raw[31:2], 2'b00};
          misalign = |npc_raw[1:0];
          state_d  = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Keep the pipeline quiet while reset is asserted, even before the first reset edge.
    if (!clrn) begin
      imem_req = 1'b0;
      fvalid   = 1'b0;
      misalign = 1'b0;
    end
  end

  // Presented instruction is a NOP bubble whenever nothing valid is held.
  always_comb begin
    imem_addr = pc_q;
    pc4       = pc_plus4;
    ins       = fvalid ? ir_q : 32'h0;
  end

  // State, pc and instruction register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      pc_q    <= 32'h0;
      ir_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule
